// File: rtl/spi_dac_rx_if.sv
// SPI pin bundle between the DAC-frame master and the DAC emulator.
// Ports: spi_sck, spi_sdi, spi_dac_cs (master->slave), spi_sdo (echo).
interface spi_dac_rx_if;
  logic spi_sck;
  logic spi_sdi;
  logic spi_dac_cs;
  logic spi_sdo;

  modport master (
    output spi_sck,
    output spi_sdi,
    output spi_dac_cs,
    input  spi_sdo
  );

  modport slave (
    input  spi_sck,
    input  spi_sdi,
    input  spi_dac_cs,
    output spi_sdo
  );
endinterface

// File: rtl/spi_dac_rx.sv
// Quad 12-bit DAC emulator: SPI frame receiver with input/DAC registers.
// Ports: clk, reset_n, spi (slave), dac_[a-d]_out, upd_stb, frame_err.
module spi_dac_rx #(
  parameter int DSZ  = 12,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_dac_rx_if.slave    spi,
  output logic [DSZ-1:0] dac_a_out,
  output logic [DSZ-1:0] dac_b_out,
  output logic [DSZ-1:0] dac_c_out,
  output logic [DSZ-1:0] dac_d_out,
  output logic           upd_stb,
  output logic           frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_t;

  state_t state;

  logic [SYNC-1:0] sck_sy;
  logic [SYNC-1:0] sdi_sy;
  logic [SYNC-1:0] cs_sy;
  logic            sck_q;
  logic            cs_q;

  logic            sck_s;
  logic            sdi_s;
  logic            cs_s;
  logic            sck_rise;
  logic            sck_fall;
  logic            cs_rise;
  logic            cs_fall;

  logic [5:0]      cnt;
  logic [31:0]     rx;
  logic [31:0]     tx;
  logic [31:0]     echo;

  logic [3:0][DSZ-1:0] in_r;
  logic [3:0][DSZ-1:0] dac_r;
  logic [3:0][DSZ-1:0] in_nxt;
  logic [3:0][DSZ-1:0] dac_nxt;

  logic [3:0]      cmd;
  logic [3:0]      adr;
  logic [DSZ-1:0]  dat;
  logic [3:0]      sel;
  logic [3:0]      ld;
  logic            wr;

  assign sck_s = sck_sy[SYNC-1];
  assign sdi_s = sdi_sy[SYNC-1];
  assign cs_s  = cs_sy[SYNC-1];

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_fall  = ~cs_s & cs_q;

  assign cmd = rx[23:20];
  assign adr = rx[19:16];
  assign dat = rx[4 +: DSZ];

  // Channel select, then per-command input write and DAC load masks.
  // Command 2 loads every DAC from the already-updated input registers.
  always_comb begin
    sel = '0;
    unique case (1'b1)
      (adr < 4'd4):  sel = 4'b0001 << adr[1:0];
      (adr == 4'hF): sel = 4'hF;
      default:       sel = '0;
    endcase

    wr = 1'b0;
    ld = '0;
    unique case (1'b1)
      (cmd == 4'h0): wr = 1'b1;
      (cmd == 4'h1): ld = sel;
      (cmd == 4'h2): begin
        wr = 1'b1;
        ld = {4{|sel}};
      end
      (cmd == 4'h3): begin
        wr = 1'b1;
        ld = sel;
      end
      default: ;
    endcase

    in_nxt  = in_r;
    dac_nxt = dac_r;
    for (int i = 0; i < 4; i++) begin
      if (wr && sel[i])
        in_nxt[i] = dat;
      if (ld[i])
        dac_nxt[i] = in_nxt[i];
    end
  end

  // Sync regs reset to 0, so a cs held low through reset release
  // never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sy    <= '0;
      sdi_sy    <= '0;
      cs_sy     <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      echo      <= '0;
      in_r      <= '0;
      dac_r     <= '0;
      upd_stb   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_sy    <= {sck_sy[SYNC-2:0], spi.spi_sck};
      sdi_sy    <= {sdi_sy[SYNC-2:0], spi.spi_sdi};
      cs_sy     <= {cs_sy[SYNC-2:0], spi.spi_dac_cs};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
      upd_stb   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            cnt   <= '0;
            tx    <= echo;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (sck_rise) begin
            rx <= {rx[30:0], sdi_s};
            if (cnt != 6'd63)
              cnt <= cnt + 6'd1;
          end
          if (sck_fall)
            tx <= {tx[30:0], 1'b0};
          if (cs_rise)
            state <= DECODE;
        end

        DECODE: begin
          if (cnt == 6'd32) begin
            in_r    <= in_nxt;
            dac_r   <= dac_nxt;
            upd_stb <= |ld;
            echo    <= rx;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Echo only drives while a frame is being shifted.
  assign spi.spi_sdo = (state == SHIFT) & tx[31];

  assign dac_a_out = dac_r[0];
  assign dac_b_out = dac_r[1];
  assign dac_c_out = dac_r[2];
  assign dac_d_out = dac_r[3];

endmodule

// File: tb/tb_spi_dac_rx.sv
// Bench for spi_dac_rx: directed frames plus random frames vs a frame model.
// Drives SPI via the interface, checks DAC outputs, strobes and echo.
module tb_spi_dac_rx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] da, db, dc, dd;
  logic        upd_stb, frame_err;

  spi_dac_rx_if bus();

  spi_dac_rx #(.DSZ(12), .SYNC(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi       (bus.slave),
    .dac_a_out (da),
    .dac_b_out (db),
    .dac_c_out (dc),
    .dac_d_out (dd),
    .upd_stb   (upd_stb),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_tot = 0;
  int err_tot = 0;

  always @(posedge clk) begin
    if (upd_stb)   upd_tot <= upd_tot + 1;
    if (frame_err) err_tot <= err_tot + 1;
  end

  logic [11:0] m_in  [4];
  logic [11:0] m_dac [4];
  logic [31:0] m_echo;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
    m_echo = '0;
  endfunction

  // Applies a complete 32-bit frame; returns 1 if a DAC load happens.
  function automatic int model_apply(input logic [31:0] w);
    int  c = int'((w >> 20) & 32'hF);
    int  a = int'((w >> 16) & 32'hF);
    logic [11:0] d = w[15:4];
    bit  en[4];
    bit  any = 0;
    for (int i = 0; i < 4; i++) begin
      en[i] = (a == i) || (a == 15);
      if (en[i]) any = 1;
    end
    m_echo = w;
    if (c == 0 || c == 2 || c == 3)
      for (int i = 0; i < 4; i++)
        if (en[i]) m_in[i] = d;
    if (c == 1 || c == 3)
      for (int i = 0; i < 4; i++)
        if (en[i]) m_dac[i] = m_in[i];
    if (c == 2 && any)
      for (int i = 0; i < 4; i++)
        m_dac[i] = m_in[i];
    return ((c >= 1 && c <= 3) && any) ? 1 : 0;
  endfunction

  // Sends the low nbits of {32'h0, w}, MSB first; captures first 32 sdo bits.
  task automatic send(input logic [31:0] w, input int nbits,
                      output logic [31:0] cap);
    logic [63:0] v = {32'h0, w};
    cap = '0;
    @(negedge clk);
    bus.spi_dac_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_sdi = v[i];
      repeat (4) @(negedge clk);
      if (nbits - 1 - i < 32)
        cap = {cap[30:0], bus.spi_sdo};
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.spi_dac_cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] w, input int nbits,
                       input string tag);
    int          u0   = upd_tot;
    int          e0   = err_tot;
    logic [31:0] prev = m_echo;
    logic [31:0] cap;
    int          hit  = 0;
    send(w, nbits, cap);
    if (nbits == 32)
      hit = model_apply(w);
    chk({tag, ".a"}, 32'(da), 32'(m_dac[0]));
    chk({tag, ".b"}, 32'(db), 32'(m_dac[1]));
    chk({tag, ".c"}, 32'(dc), 32'(m_dac[2]));
    chk({tag, ".d"}, 32'(dd), 32'(m_dac[3]));
    chk({tag, ".upd"}, 32'(upd_tot - u0), 32'(hit));
    chk({tag, ".err"}, 32'(err_tot - e0), (nbits == 32) ? 32'd0 : 32'd1);
    if (nbits >= 32)
      chk({tag, ".echo"}, cap, prev);
  endtask

  initial begin
    logic [31:0] w;
    int          nb;
    int          e0;
    int          sc, sa;

    bus.spi_sck    = 1'b0;
    bus.spi_sdi    = 1'b0;
    bus.spi_dac_cs = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.a", 32'(da), 32'd0);
    chk("rst.d", 32'(dd), 32'd0);
    chk("rst.upd", 32'(upd_stb), 32'd0);
    chk("rst.err", 32'(frame_err), 32'd0);
    chk("rst.sdo", 32'(bus.spi_sdo), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    frame(32'h0030ABC0, 32, "w3a");
    frame(32'h00025550, 32, "w0c");
    frame(32'h00120000, 32, "cp1c");
    frame(32'h003F7FF0, 32, "w3all");
    frame(32'h0031FFF0, 31, "short");
    frame(32'h0031FFF0, 33, "long");
    frame(32'h00301230, 32, "echo1");
    frame(32'hDEAD0000, 32, "echo2");
    frame(32'h0020F120, 32, "w2a");
    frame(32'h00360000, 32, "badadr");

    // Reset after 16 sck edges with cs still low.
    e0 = err_tot;
    @(negedge clk);
    bus.spi_dac_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.spi_sdi = i[0];
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid.a", 32'(da), 32'd0);
    chk("mid.sdo", 32'(bus.spi_sdo), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_dac_cs = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid.err", 32'(err_tot - e0), 32'd0);
    frame(32'h0033FED0, 32, "mid.new");

    for (int k = 0; k < 40; k++) begin
      sc = $urandom_range(0, 5);
      sa = $urandom_range(0, 5);
      if (sc == 4)      sc = 15;
      else if (sc == 5) sc = $urandom_range(4, 14);
      if (sa == 4)      sa = 15;
      else if (sa == 5) sa = $urandom_range(4, 14);
      w = $urandom;
      w[23:20] = sc[3:0];
      w[19:16] = sa[3:0];
      nb = 32;
      if ($urandom_range(0, 7) == 0)
        nb = ($urandom_range(0, 1) == 0) ? 31 : 33;
      frame(w, nb, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
